// File: rtl/osc_pulse_monitor_if.sv
// osc_pulse_monitor_if: oscillator line in, pulse/measurement/status bundle out
interface osc_pulse_monitor_if #(
  parameter int CNT_W = 8
);
  logic             osc_in;
  logic             err_clear;
  logic             pulse;
  logic             measure_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_width;
  logic             locked;
  logic             osc_dead;
  logic             period_err;
  logic             width_err;
  modport master (
    output osc_in, err_clear,
    input  pulse, measure_valid, period, high_width, locked, osc_dead, period_err, width_err
  );
  modport slave (
    input  osc_in, err_clear,
    output pulse, measure_valid, period, high_width, locked, osc_dead, period_err, width_err
  );
endinterface

// File: rtl/osc_pulse_monitor.sv
// osc_pulse_monitor: syncs the oscillator line, strobes each pulse, measures and checks period/high width
module osc_pulse_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int MIN_PERIOD  = 9,
  parameter int MAX_PERIOD  = 11,
  parameter int MIN_HIGH    = 1,
  parameter int MAX_HIGH    = 3,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 32
) (
  input logic               clk,
  input logic               rst,
  osc_pulse_monitor_if.slave bus
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT  = '1;
  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] MINH = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAXH = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] TO   = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LOCK_C = GW'(LOCK_COUNT);
  typedef enum logic [1:0] {NOSYNC, HIGH, LOW, DEAD} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic hist_q, sync, rise, fall;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d, hw_q, hw_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [GW-1:0] good_q, good_d;
  logic wbad_q, wbad_d, pulse_q, pulse_d, mv_q, mv_d, locked_q, locked_d;
  logic dead_q, dead_d, perr_q, perr_d, werr_q, werr_d, perr_new, werr_new;
  assign sync   = sync_q[SYNC_STAGES-1];
  assign rise   = sync & ~hist_q;
  assign fall   = ~sync & hist_q;
  assign pcnt_d = rise ? ONE : (pcnt_q == SAT ? SAT : pcnt_q + ONE);
  assign hcnt_d = rise ? ONE : ((sync && hcnt_q != SAT) ? hcnt_q + ONE : hcnt_q);
  assign bus.pulse         = pulse_q;
  assign bus.measure_valid = mv_q;
  assign bus.period        = period_q;
  assign bus.high_width    = high_q;
  assign bus.locked        = locked_q;
  assign bus.osc_dead      = dead_q;
  assign bus.period_err    = perr_q;
  assign bus.width_err     = werr_q;
  // synchronizer chain plus history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.osc_in};
      hist_q <= sync;
    end
  end
  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NOSYNC;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      hw_q     <= '0;
      good_q   <= '0;
      wbad_q   <= 1'b0;
      pulse_q  <= 1'b0;
      mv_q     <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      locked_q <= 1'b0;
      dead_q   <= 1'b0;
      perr_q   <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      hw_q     <= hw_d;
      good_q   <= good_d;
      wbad_q   <= wbad_d;
      pulse_q  <= pulse_d;
      mv_q     <= mv_d;
      period_q <= period_d;
      high_q   <= high_d;
      locked_q <= locked_d;
      dead_q   <= dead_d;
      perr_q   <= perr_d;
      werr_q   <= werr_d;
    end
  end
  // next state: a rise measures only when coming from LOW; timeout beats a fall
  always_comb begin
    state_d  = state_q;
    hw_d     = hw_q;
    good_d   = good_q;
    wbad_d   = wbad_q;
    pulse_d  = rise;
    mv_d     = 1'b0;
    period_d = period_q;
    high_d   = high_q;
    locked_d = locked_q;
    dead_d   = dead_q;
    perr_new = 1'b0;
    werr_new = 1'b0;
    if (rise) begin
      state_d = HIGH;
      dead_d  = 1'b0;
      wbad_d  = 1'b0;
      if (state_q == LOW) begin
        mv_d     = 1'b1;
        period_d = pcnt_q;
        high_d   = hw_q;
        if (pcnt_q < MINP || pcnt_q > MAXP) begin
          perr_new = 1'b1;
          good_d   = '0;
          locked_d = 1'b0;
        end else if (!wbad_q) begin
          good_d   = (good_q == LOCK_C) ? good_q : good_q + GW'(1);
          locked_d = locked_q | (good_d == LOCK_C);
        end
      end
    end else if (pcnt_q == TO) begin
      state_d  = DEAD;
      dead_d   = 1'b1;
      locked_d = 1'b0;
      good_d   = '0;
    end else if (fall && state_q == HIGH) begin
      state_d = LOW;
      hw_d    = hcnt_q;
      if (hcnt_q < MINH || hcnt_q > MAXH) begin
        werr_new = 1'b1;
        wbad_d   = 1'b1;
        good_d   = '0;
        locked_d = 1'b0;
      end
    end
    perr_d = (perr_q & ~bus.err_clear) | perr_new;
    werr_d = (werr_q & ~bus.err_clear) | werr_new;
  end
endmodule
